// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Samples a time-multiplexed 7-segment display bus and recovers the BCD digit
//   shown in each position. A digit is captured once its {an, seg} pattern has
//   been sampled identically STABLE times in a row, and only once per stable run.
//
// Ports
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset
//   seg_i    segment lines, bit6 = a ... bit0 = g, 1 = lit
//   an_i     one-hot digit enables, bit n = position n
//   bcd_o    recovered digits, bits [4n+3:4n] = position n
//   valid_o  bit n set while slice n holds a legal capture
//   err_o    one-cycle pulse: stable, enabled pattern that is not a digit
//   frame_o  one-cycle pulse: every position captured since the last pulse
//
// Build option
//   SEG7_ACTIVE_LOW_EN  inverts seg_i and an_i ahead of the sample register
//                       (common-anode displays). Outputs are unchanged.

module seg7_scan_decoder #(
  parameter int DIGITS = 6,
  parameter int STABLE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_i,
  input  logic [DIGITS-1:0]   an_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic [DIGITS-1:0]   valid_o,
  output logic                err_o,
  output logic                frame_o
);

  localparam int         SW       = DIGITS + 7;
  localparam logic [3:0] STABLE_C = 4'(STABLE);

  logic [SW-1:0] in_raw;

`ifdef SEG7_ACTIVE_LOW_EN
  assign in_raw = ~{an_i, seg_i};
`else
  assign in_raw = {an_i, seg_i};
`endif

  // {legal, digit}
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: decode = {1'b1, 4'd0};
      7'b0110000: decode = {1'b1, 4'd1};
      7'b1101101: decode = {1'b1, 4'd2};
      7'b1111001: decode = {1'b1, 4'd3};
      7'b0110011: decode = {1'b1, 4'd4};
      7'b1011011: decode = {1'b1, 4'd5};
      7'b1011111: decode = {1'b1, 4'd6};
      7'b1110000: decode = {1'b1, 4'd7};
      7'b1111111: decode = {1'b1, 4'd8};
      7'b1111011: decode = {1'b1, 4'd9};
      default:    decode = 5'b0;
    endcase
  endfunction

  logic [SW-1:0]       samp_q,  samp_d;
  logic [3:0]          cnt_q,   cnt_d;
  logic                armed_q, armed_d;
  logic [DIGITS-1:0]   seen_q,  seen_d;
  logic [4*DIGITS-1:0] bcd_q,   bcd_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic                err_q,   err_d;
  logic                frame_q, frame_d;

  logic              changed;
  logic              fire;
  logic              onehot;
  logic [DIGITS-1:0] an_s;
  logic [4:0]        dec;
  logic [DIGITS-1:0] seen_nxt;

  always_comb begin
    samp_d   = in_raw;
    an_s     = samp_q[SW-1:7];
    dec      = decode(samp_q[6:0]);
    changed  = (in_raw != samp_q);
    // Run has been stable for STABLE samples and not yet acted upon.
    fire     = armed_q && (cnt_q == STABLE_C);
    onehot   = (an_s != '0) && ((an_s & (an_s - DIGITS'(1))) == '0);

    if (changed) begin
      cnt_d = 4'd1;
    end else if (cnt_q != STABLE_C) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end

    // A change on the same edge as an action starts a fresh run, so it wins.
    armed_d = armed_q;
    if (fire)    armed_d = 1'b0;
    if (changed) armed_d = 1'b1;

    bcd_d    = bcd_q;
    valid_d  = valid_q;
    seen_d   = seen_q;
    seen_nxt = seen_q;
    err_d    = 1'b0;
    frame_d  = 1'b0;

    if (fire && onehot) begin
      if (dec[4]) begin
        for (int n = 0; n < DIGITS; n++) begin
          if (an_s[n]) bcd_d[4*n +: 4] = dec[3:0];
        end
        valid_d  = valid_q | an_s;
        seen_nxt = seen_q | an_s;
        if (&seen_nxt) begin
          frame_d = 1'b1;
          seen_d  = '0;
        end else begin
          seen_d  = seen_nxt;
        end
      end else begin
        err_d   = 1'b1;
        valid_d = valid_q & ~an_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_q  <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      seen_q  <= '0;
      bcd_q   <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      samp_q  <= samp_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      seen_q  <= seen_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      frame_q <= frame_d;
    end
  end

  assign bcd_o   = bcd_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign frame_o = frame_q;

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the watch's BCD-to-7-segment decoder. It samples a time-multiplexed 7-segment display bus (segment lines plus one-hot digit enables) and recovers the BCD digit shown in each position. A digit is captured only after its pattern has been stable for a configurable number of cycles. The block sits in the self-test and readback path, where it checks what the display driver actually presents.

## Interface
Parameters:
- DIGITS, 6: number of multiplexed digit positions (HH:MM:SS).
- STABLE, 4: consecutive identical samples required before a capture. Legal range 2..15.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- seg_i  input  7  segment lines; bit6=a … bit0=g; 1 = segment lit.
- an_i  input  DIGITS  digit enables; bit n = position n; 1 = enabled.
- bcd_o  output  4*DIGITS  recovered digits; bits [4n+3:4n] belong to position n.
- valid_o  output  DIGITS  bit n = 1 when bcd_o slice n holds a legal capture.
- err_o  output  1  one-cycle pulse: a stable, enabled pattern was not a legal digit.
- frame_o  output  1  one-cycle pulse: every position has had a legal capture since the previous pulse.

## Operation
- **Input register.** {an_i, seg_i} is registered into a sample register every cycle.
- **Run counter.**
  - Counts the consecutive edges on which the new sample equals the previous sample.
  - Any difference reloads the counter to 1.
  - Saturates at STABLE.
- **Armed flag.**
  - Set whenever the sample changes.
  - Cleared when a capture or error is taken.
  - At most one capture per stable run.
- **Capture condition.** Counter reaches STABLE, the armed flag is set, and the sampled an is exactly one-hot. If an is all-zero or multi-hot (blanking or overlap), no action is taken and the armed flag is cleared.
- **Decode**, segment pattern a..g to digit:
  - 1111110 → 0, 0110000 → 1, 1101101 → 2, 1111001 → 3, 0110011 → 4
  - 1011011 → 5, 1011111 → 6, 1110000 → 7, 1111111 → 8, 1111011 → 9
- **Legal pattern.** Write the digit to bcd_o slice n, set valid_o[n], and set bit n of the internal seen-mask.
- **Illegal pattern** (any other value, including all-off):
  - Pulse err_o.
  - Clear valid_o[n].
  - bcd_o slice n keeps its old value.
  - The seen-mask is unchanged.
- **Frame.** When the seen-mask becomes all ones, frame_o pulses and the mask clears.
- **Reset.**
  - bcd_o = 0, valid_o = 0, err_o = 0, frame_o = 0.
  - Counter = 0, armed = 0, seen-mask = 0.
  - Reset mid-run discards the partial run. After release, a full STABLE run is required before any capture.

## Timing
- **Capture latency.** Inputs change before edge k and are held. Outputs update on edge k+STABLE, so they are visible after that edge.
- **Short runs.** A run shorter than STABLE edges produces nothing.
- **Held inputs.** Holding the inputs indefinitely produces exactly one capture.
- **Same-edge frame.** The capture that completes the mask updates bcd_o/valid_o and pulses frame_o on the same edge.
- **Pulse width.** err_o and frame_o are high for exactly one cycle. They are never high together: an error never completes a frame.
- **Re-capturing a position.** A repeated capture of an already-seen position overwrites its slice and does not affect the mask.
- **Same value, new run.** After a blank gap (an = 0), the same digit value is captured again.

## Configuration
- **SEG7_ACTIVE_LOW_EN defined:** seg_i and an_i are inverted before the input register. Use this for common-anode displays, where 0 = lit or enabled. All decode and one-hot rules then apply to the inverted values.
- **Not defined:** inputs are active-high as listed above.
- Outputs are identical in both builds.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles with an_i=000001, seg_i=1111110 → bcd_o=0, valid_o=0, err_o=0 throughout. After release, valid_o[0]=1 appears exactly STABLE edges later.
- **Short run:** STABLE=4, an_i=000100, seg_i=1111001 held for 3 edges then an_i=0 → no capture. Held for 4 edges → bcd_o[11:8]=3, valid_o[2]=1.
- **Full frame:** scan positions 0..5 showing 5,9,4,1,2,0 (run 6, gap 2) → frame_o pulses once, on the edge capturing position 5. bcd_o=0x021495 (slice n = position n), valid_o=111111.
- **Illegal pattern:** position 1 holds 7 (valid), then seg_i=0000001 held 4 edges → err_o single pulse, valid_o[1]=0, bcd_o[7:4] stays 7, no frame_o.
- **Invalid enables:** an_i=000011 with seg_i=1111111 held 20 cycles → no capture, no err_o. Changing to 000010 then captures 8 once.
- **Active-low build** (SEG7_ACTIVE_LOW_EN): an_i=111110, seg_i=0001111 (inverted 7) → bcd_o[3:0]=7, valid_o[0]=1.
